mic1_uart_tx: RTL and testbench
===============================

MIC1_UART_TX -- requirements
Module: mic1_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, meaning clock cycles per bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the byte buffer depth; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send, sampled on an accepted handshake.
REQ-006 SHALL have port tx_valid  input  1  producer offers tx_data.
REQ-007 SHALL have port tx_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port ser_tx  output  1  serial line, 8N1, idle high, registered.
REQ-009 SHALL have port busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-010 SHALL accept a byte on every rising edge where tx_valid and tx_ready are both high, and ignore tx_data otherwise.
REQ-011 SHALL drive tx_ready = not FIFO-full, taken from registered state only (no combinational path from tx_valid).
REQ-012 SHALL write into a full FIFO never; a push in the same cycle as a pop of a full FIFO is not accepted (tx_ready low that cycle).
REQ-013 SHALL run an FSM with states IDLE, START, DATA, STOP.
REQ-014 IDLE: ser_tx=1; if FIFO non-empty, pop head into the shift register, load the bit counter with CLK_DIV-1, go to START.
REQ-015 START: ser_tx=0 for exactly CLK_DIV cycles, then DATA with bit index 0.
REQ-016 DATA: ser_tx=shift[0], LSB first, each bit held exactly CLK_DIV cycles; after bit 7 go to STOP.
REQ-017 STOP: ser_tx=1 for exactly CLK_DIV cycles; at its end, if FIFO non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-018 SHALL make one frame exactly 10*CLK_DIV cycles from the first low cycle of the start bit to the end of the stop bit.
REQ-019 Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE -> ser_tx low from edge N+1.
REQ-020 SHALL change tx_data/tx_valid mid-frame without affecting the frame in flight.
REQ-021 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, with an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-022 SHALL drive busy = (state != IDLE) or (FIFO count != 0), registered-state derived.

Reset
REQ-023 While resetn is low at a rising edge: state=IDLE, FIFO emptied, counters zero, ser_tx=1, tx_ready=0, busy=0.
REQ-024 tx_ready SHALL rise on the first edge after resetn returns high.
REQ-025 Reset asserted mid-frame SHALL abort the frame; ser_tx is high from the next edge and the buffered bytes are discarded.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, START, DATA, STOP) and the default divider constant in shared package mic1_uart_pkg, for reuse by the future receiver.
REQ-027 SHALL implement the buffer as sub-module mic1_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), same clk/resetn.
REQ-028 The FSM, bit-period counter and shift register SHALL live in mic1_uart_tx itself.

Verification (CLK_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-029 Single byte 0xA5 into idle block -> ser_tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; 40 cycles total; busy falls after stop.
REQ-030 Five bytes 0x01..0x05 pushed back-to-back with tx_valid held -> tx_ready low when 4 are buffered, fifth accepted after first pop; five contiguous frames, 200 cycles, no idle gap.
REQ-031 Frame rate check with default CLK_DIV=104, byte 0x55 -> each bit exactly 104 cycles, frame 1040 cycles.
REQ-032 resetn pulsed low for 1 cycle at cycle 17 of a 0x00 frame with 2 bytes queued -> ser_tx=1 from next edge, busy=0, no further frames emitted.
REQ-033 tx_valid high with tx_data toggling while full -> nothing written; sent bytes equal exactly the accepted handshakes in order.
REQ-034 Scoreboard bench with a reference 8N1 sampler in the middle of each bit, 1000 random bytes with random tx_valid gaps -> all bytes received in order, zero framing errors.

Source files
------------

// File: rtl/mic1_uart_pkg.sv
// rtl/mic1_uart_pkg.sv - shared UART definitions (FSM states, default divider)
package mic1_uart_pkg;

  // Line-level frame phases, shared with the future receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 12 MHz clock / 115200 baud.
  localparam int DEFAULT_CLK_DIV = 104;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/mic1_sync_fifo.sv
// rtl/mic1_sync_fifo.sv - single-clock FIFO with occupancy count
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   write request and data; ignored while full
//   pop, pop_data     read request; pop_data shows the head (first-word fall-through)
//   full, empty       occupancy flags
//   count             number of stored words, 0..DEPTH
module mic1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mic1_uart_tx.sv
// rtl/mic1_uart_tx.sv - buffered 8N1 UART transmitter
//
// Ports:
//   clk        single clock, rising edge
//   resetn     synchronous active-low reset; aborts any frame, drops buffered bytes
//   tx_data    byte to send, captured when tx_valid && tx_ready
//   tx_valid   producer offers tx_data
//   tx_ready   a byte can be accepted this cycle (buffer not full)
//   ser_tx     registered serial output, idle high
//   busy       buffer non-empty or a frame on the line
module mic1_uart_tx
  import mic1_uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ser_tx,
  output logic       busy
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  uart_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ser_q, ser_d;
  logic        ready_q;

  logic          push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  // ready_q holds tx_ready low through reset and for the reset edge itself;
  // the rest is pure buffer state, so tx_valid never feeds tx_ready.
  assign tx_ready = ready_q && !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign ser_tx   = ser_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

  mic1_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    ser_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          cnt_d    = BIT_LAST;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LAST;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            cnt_d    = BIT_LAST;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decided from the next state so ser_tx can be a
    // plain register that changes on the same edge as the state.
    case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_d[0];
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mic1_uart_tx.sv
// tb/tb_mic1_uart_tx.sv - self-checking bench for mic1_uart_tx
module tb_mic1_uart_tx;

  localparam int DIV      = 4;
  localparam int SLOW_DIV = 104;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ser_tx;
  logic       busy;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       ser_tx2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  logic       wave[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         rec_en = 1'b0;
  bit         rx_en  = 1'b0;
  int         framing_errs = 0;

  always #5 clk = ~clk;

  mic1_uart_tx #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_tx   (ser_tx),
    .busy     (busy)
  );

  mic1_uart_tx #(
    .FIFO_DEPTH (4)
  ) dut_slow (
    .clk      (clk),
    .resetn   (resetn),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .ser_tx   (ser_tx2),
    .busy     (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 line waveform for one byte, one entry per clock cycle.
  task automatic push_wave(input logic [7:0] b, input int div);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      repeat (div) wave.push_back(v);
    end
  endtask

  // Accepted handshakes, in order.
  always @(negedge clk) begin
    if (rec_en && tx_valid && tx_ready) exp_q.push_back(tx_data);
  end

  // Reference receiver: samples each bit in its middle.
  initial begin : rx_model
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && ser_tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        if (ser_tx !== 1'b0) framing_errs++;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (DIV) @(negedge clk);
        if (ser_tx !== 1'b1) framing_errs++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser: got %b expected 1", ser_tx); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ser_tx2 !== 1'b1) begin errors++; $display("FAIL reset_ser_slow: got %b expected 1", ser_tx2); end
    resetn = 1'b1;
    tick();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", tx_ready); end
    checks++; if (tx_ready2 !== 1'b1) begin errors++; $display("FAIL ready_after_reset_slow: got %b expected 1", tx_ready2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_reset: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    logic exp;
    int   n;
    wave.delete();
    push_wave(8'hA5, DIV);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    checks++; if (ser_tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_accept: ser=%b busy=%b expected ser=1 busy=1", ser_tx, busy); end
    n = wave.size();
    for (int k = 0; k < n; k++) begin
      tick();
      exp = wave.pop_front();
      checks++; if (ser_tx !== exp) begin errors++; $display("FAIL single_wave cycle %0d: got %b expected %b", k, ser_tx, exp); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_stop: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || ser_tx !== 1'b1) begin errors++; $display("FAIL single_end: busy=%b ser=%b expected busy=0 ser=1", busy, ser_tx); end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   guard = 0;
    int   k = 0;
    bit   started = 1'b0;
    bit   hs;
    logic exp;
    wave.delete();
    for (int b = 1; b <= 5; b++) push_wave(8'(b), DIV);
    tx_data  = 8'd1;
    tx_valid = 1'b1;
    while ((sent < 5 || wave.size() > 0) && guard < 400) begin
      hs = tx_valid && tx_ready;
      tick();
      guard++;
      if (started && wave.size() > 0) begin
        exp = wave.pop_front();
        checks++; if (ser_tx !== exp) begin errors++; $display("FAIL b2b_wave cycle %0d: got %b expected %b", k, ser_tx, exp); end
        k++;
      end
      if (hs) begin
        sent++;
        started = 1'b1;
        if (sent == 5) begin
          tx_valid = 1'b0;
          checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", tx_ready); end
        end else begin
          tx_data = 8'(sent + 1);
        end
      end
    end
    checks++; if (guard >= 400) begin errors++; $display("FAIL b2b_timeout: sent %0d of 5, %0d wave cycles left", sent, wave.size()); end
    checks++; if (k != 200) begin errors++; $display("FAIL b2b_length: got %0d cycles expected 200", k); end
    tick();
    checks++; if (busy !== 1'b0 || ser_tx !== 1'b1) begin errors++; $display("FAIL b2b_end: busy=%b ser=%b expected busy=0 ser=1", busy, ser_tx); end
  endtask

  task automatic test_rate();
    logic exp;
    int   n;
    int   bad = 0;
    wave.delete();
    push_wave(8'h55, SLOW_DIV);
    tx_data2  = 8'h55;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    n = wave.size();
    checks++; if (n != 1040) begin errors++; $display("FAIL rate_model_len: got %0d expected 1040", n); end
    for (int k = 0; k < n; k++) begin
      tick();
      exp = wave.pop_front();
      checks++; if (ser_tx2 !== exp) begin errors++; bad++; if (bad < 5) $display("FAIL rate_wave cycle %0d: got %b expected %b", k, ser_tx2, exp); end
    end
    tick();
    checks++; if (busy2 !== 1'b0 || ser_tx2 !== 1'b1) begin errors++; $display("FAIL rate_end: busy=%b ser=%b expected busy=0 ser=1", busy2, ser_tx2); end
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    tx_data  = 8'hC3;
    tick();
    tx_data  = 8'h3C;
    tick();
    tx_valid = 1'b0;
    repeat (15) tick();
    checks++; if (ser_tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_midframe: ser=%b busy=%b expected ser=0 busy=1", ser_tx, busy); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL abort_ser: got %b expected 1", ser_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_low: got %b expected 0", tx_ready); end
    tick();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back: got %b expected 1", tx_ready); end
    for (int k = 0; k < 100; k++) begin
      if (ser_tx !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_full_ignore();
    bit full_seen = 1'b0;
    int guard = 0;
    exp_q.delete();
    rx_q.delete();
    framing_errs = 0;
    rec_en = 1'b1;
    rx_en  = 1'b1;
    tx_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tx_data = 8'($urandom);
      if (!tx_ready) full_seen = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    rec_en   = 1'b0;
    while (busy && guard < 1000) begin tick(); guard++; end
    repeat (2 * DIV) tick();
    rx_en = 1'b0;
    checks++; if (guard >= 1000) begin errors++; $display("FAIL full_drain_timeout: busy=%b after %0d cycles", busy, guard); end
    checks++; if (!full_seen) begin errors++; $display("FAIL full_not_reached: tx_ready never low"); end
    checks++; if (exp_q.size() < 6 || exp_q.size() > 9) begin errors++; $display("FAIL full_accept_count: got %0d expected 6..9", exp_q.size()); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL full_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte %0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (framing_errs != 0) begin errors++; $display("FAIL full_framing: got %0d expected 0", framing_errs); end
  endtask

  task automatic test_random();
    int n_cyc = 0;
    int guard = 0;
    exp_q.delete();
    rx_q.delete();
    framing_errs = 0;
    rec_en = 1'b1;
    rx_en  = 1'b1;
    while (exp_q.size() < 1000 && n_cyc < 80000) begin
      if ($urandom_range(0, 9) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 30)) begin tick(); n_cyc++; end
      end else begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        tick();
        n_cyc++;
      end
    end
    tx_valid = 1'b0;
    rec_en   = 1'b0;
    while (busy && guard < 1000) begin tick(); guard++; end
    repeat (2 * DIV) tick();
    rx_en = 1'b0;
    checks++; if (n_cyc >= 80000 || guard >= 1000) begin errors++; $display("FAIL random_timeout: cycles=%0d drain=%0d", n_cyc, guard); end
    checks++; if (exp_q.size() != 1000) begin errors++; $display("FAIL random_accepted: got %0d expected 1000", exp_q.size()); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL random_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte %0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (framing_errs != 0) begin errors++; $display("FAIL random_framing: got %0d expected 0", framing_errs); end
  endtask

  initial begin
    resetn    = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid2 = 1'b0;
    tx_data2  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_rate();
    test_reset_abort();
    test_full_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
